out_wrapper: RTL and testbench

- Output-side counterpart of the operand input wrapper.
- Captures one FP result word (plus IEEE exception flags) when the FP core signals completion.
- Presents the result on a 32-bit output bus using a 4-phase ready/accepted handshake, with this block as initiator and the external consumer as responder.
- Sits between the FP core and the system bus, mirroring the input handshake in the opposite direction.

---
 rtl/out_wrapper.sv | 102 ++++++++++
 tb/tb_out_wrapper.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_wrapper.sv
// out_wrapper: captures one FP result on fpDone and hands it to the consumer over a
// 4-phase outReady/outAccepted handshake. OUT_WRAPPER_FLAGS_WORD_EN adds a second flags word.
module out_wrapper #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FLAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fpDone,
    input  logic [DATA_W-1:0] fpResult,
    input  logic [FLAG_W-1:0] fpFlags,
    output logic [DATA_W-1:0] outBus,
    output logic              outReady,
    input  logic              outAccepted,
    output logic              wrapperReady,
    output logic              overrun
);

`ifdef OUT_WRAPPER_FLAGS_WORD_EN
    typedef enum logic [2:0] {StIdle, StSend, StAckLow, StFSend, StFAckLow} state_e;
`else
    typedef enum logic [1:0] {StIdle, StSend, StAckLow} state_e;
`endif

    state_e              state_q;
    logic [DATA_W-1:0]   result_q;
    logic [FLAG_W-1:0]   flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            result_q     <= '0;
            flags_q      <= '0;
            outBus       <= '0;
            outReady     <= 1'b0;
            wrapperReady <= 1'b1;
            overrun      <= 1'b0;
        end else begin
            // A result arriving while busy is dropped; only the sticky flag records it.
            if (fpDone && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (fpDone) begin
                        result_q     <= fpResult;
                        flags_q      <= fpFlags;
                        outBus       <= fpResult;
                        outReady     <= 1'b1;
                        wrapperReady <= 1'b0;
                        state_q      <= StSend;
                    end
                end
                StSend: begin
                    outBus <= result_q;
                    if (outAccepted) begin
                        outReady <= 1'b0;
                        state_q  <= StAckLow;
                    end
                end
                StAckLow: begin
                    if (!outAccepted) begin
`ifdef OUT_WRAPPER_FLAGS_WORD_EN
                        outBus   <= {{(DATA_W-FLAG_W){1'b0}}, flags_q};
                        outReady <= 1'b1;
                        state_q  <= StFSend;
`else
                        wrapperReady <= 1'b1;
                        state_q      <= StIdle;
`endif
                    end
                end
`ifdef OUT_WRAPPER_FLAGS_WORD_EN
                StFSend: begin
                    if (outAccepted) begin
                        outReady <= 1'b0;
                        state_q  <= StFAckLow;
                    end
                end
                StFAckLow: begin
                    if (!outAccepted) begin
                        wrapperReady <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
`endif
                default: begin
                    outReady     <= 1'b0;
                    wrapperReady <= 1'b1;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

`ifndef OUT_WRAPPER_FLAGS_WORD_EN
    // Flags are captured but never transmitted in this build.
    logic unused_flags;
    assign unused_flags = ^flags_q;
`endif

endmodule

// File: tb/tb_out_wrapper.sv
// Scoreboard bench for out_wrapper: random results and responder timing, checked in order
// against a queue of expected words; honours OUT_WRAPPER_FLAGS_WORD_EN like the design.
module tb_out_wrapper;

`ifdef OUT_WRAPPER_FLAGS_WORD_EN
    localparam int Words = 2;
`else
    localparam int Words = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fpDone = 1'b0;
    logic [31:0] fpResult = '0;
    logic [4:0]  fpFlags = '0;
    logic [31:0] outBus;
    logic        outReady;
    logic        outAccepted = 1'b0;
    logic        wrapperReady;
    logic        overrun;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic        exp_overrun = 1'b0;
    logic        model_busy = 1'b0;
    logic        resp_en = 1'b1;
    int          d1 = 2;
    int          d2 = 2;
    int          word_idx = 0;

    always #5 clk = ~clk;

    out_wrapper #(.DATA_W(32), .FLAG_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .fpDone       (fpDone),
        .fpResult     (fpResult),
        .fpFlags      (fpFlags),
        .outBus       (outBus),
        .outReady     (outReady),
        .outAccepted  (outAccepted),
        .wrapperReady (wrapperReady),
        .overrun      (overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs change 1 time unit after the falling edge; outputs are sampled on the falling edge.
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [31:0] r, input logic [4:0] f);
        logic cap;
        cap = !model_busy;
        check("wr_ready_model", wrapperReady, cap);
        fpDone   = 1'b1;
        fpResult = r;
        fpFlags  = f;
        if (cap) begin
            model_busy = 1'b1;
            exp_q.push_back(r);
            if (Words == 2) exp_q.push_back({27'd0, f});
        end else begin
            exp_overrun = 1'b1;
        end
        wait_cyc(1);
        fpDone   = 1'b0;
        fpResult = $urandom;
        fpFlags  = 5'($urandom);
        if (cap) begin
            check("capture_ready", outReady, 1'b1);
            check("capture_busy", wrapperReady, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (model_busy && n < 400) begin
            wait_cyc(1);
            n++;
        end
        if (model_busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
            model_busy = 1'b0;
        end
    endtask

    // Responder: 4-phase acknowledge with configurable delays.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (resp_en && !rst && outReady) begin
                int dly;
                dly = d1;
                for (int i = 0; i < dly; i++) begin
                    wait_cyc(1);
                    check("ready_hold", outReady, 1'b1);
                end
                outAccepted = 1'b1;
                @(negedge clk);
                check("ready_fall", outReady, 1'b0);
                #1;
                wait_cyc(d2);
                outAccepted = 1'b0;
                @(negedge clk);
                word_idx++;
                if (word_idx >= Words) begin
                    check("wr_ready_rise", wrapperReady, 1'b1);
                    word_idx   = 0;
                    model_busy = 1'b0;
                end else begin
                    check("flag_word_ready", outReady, 1'b1);
                end
            end
        end
    end

    // Monitor: pops one expected word per outReady rise; otherwise outBus must hold.
    initial begin
        logic        prev_ready;
        logic [31:0] held;
        prev_ready = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (outReady && !prev_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got %h, expected no word", outBus);
                    end else begin
                        check("word", outBus, exp_q.pop_front());
                    end
                end else begin
                    check("bus_hold", outBus, held);
                end
                check("overrun", overrun, exp_overrun);
            end
            prev_ready = outReady;
            held       = outBus;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(3);
        check("rst_bus", outBus, 32'h0);
        check("rst_ready", outReady, 1'b0);
        check("rst_wr_ready", wrapperReady, 1'b1);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        wait_cyc(2);

        // Basic transfer, responder 2 cycles each way.
        d1 = 2;
        d2 = 2;
        issue(32'h3F80_0000, 5'b10001);
        wait_idle();
        wait_cyc(2);

        // Slow responder.
        d1 = 20;
        issue(32'hC0A0_1234, 5'b00100);
        wait_idle();
        wait_cyc(1);

        // Overrun while in SEND.
        d1 = 5;
        issue(32'h3F80_0000, 5'b00001);
        wait_cyc(1);
        issue(32'h4000_0000, 5'b11111);
        check("overrun_bus_kept", outBus, 32'h3F80_0000);
        wait_idle();
        wait_cyc(3);
        check("overrun_sticky", overrun, 1'b1);

        // Reset mid-SEND drops the pending result.
        resp_en = 1'b0;
        issue(32'hDEAD_BEEF, 5'b01010);
        wait_cyc(3);
        rst         = 1'b1;
        exp_overrun = 1'b0;
        model_busy  = 1'b0;
        exp_q.delete();
        wait_cyc(1);
        check("mid_rst_ready", outReady, 1'b0);
        check("mid_rst_bus", outBus, 32'h0);
        check("mid_rst_wr_ready", wrapperReady, 1'b1);
        check("mid_rst_overrun", overrun, 1'b0);
        wait_cyc(2);
        rst     = 1'b0;
        resp_en = 1'b1;
        wait_cyc(2);

        // Back-to-back results, each issued once idle.
        d1 = 1;
        d2 = 0;
        issue(32'h0000_0014, 5'b00010);
        wait_idle();
        issue(32'h0000_0064, 5'b01000);
        wait_idle();
        wait_cyc(1);
        check("b2b_overrun", overrun, 1'b0);

        // Random traffic, including results offered while busy.
        for (int i = 0; i < 60; i++) begin
            d1 = $urandom_range(0, 3);
            d2 = $urandom_range(0, 3);
            wait_cyc($urandom_range(0, 4));
            issue($urandom, 5'($urandom));
            if ($urandom_range(0, 3) == 0) wait_idle();
        end
        wait_idle();
        wait_cyc(4);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
